// File: rtl/microcode_step_sequencer_pkg.sv
// gb_seq_pkg: shared sequencer states and opcode constants for the microcode step sequencer.
package gb_seq_pkg;
    typedef enum logic [1:0] {FETCH0, FETCH_CB, RUN, HALT} seq_state_t;
    localparam logic [7:0] OPC_CB           = 8'hCB;
    localparam logic [7:0] DEF_RESET_OPCODE = 8'h00;
endpackage

// File: rtl/microcode_step_sequencer_cycle_step_shift.sv
// cycle_step_shift: one-hot machine-cycle step register with load/clear/advance and a sticky overrun flag.
module cycle_step_shift #(
    parameter int STEP_W = 4
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic              i_Load,
    input  logic              i_Clear,
    input  logic              i_Advance,
    output logic [STEP_W-1:0] o_Step,
    output logic              o_Overrun
);
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            o_Step    <= '0;
            o_Overrun <= 1'b0;
        end else if (i_Load) begin
            o_Step <= STEP_W'(1);
        end else if (i_Clear) begin
            o_Step <= '0;
        end else if (i_Advance) begin
            // The last step saturates instead of wrapping so groups never see a phantom step 0
            if (o_Step[STEP_W-1])
                o_Overrun <= 1'b1;
            else
                o_Step <= o_Step << 1;
        end
    end
endmodule

// File: rtl/microcode_step_sequencer.sv
// microcode_step_sequencer: opcode/CB/step sequencing for the microcode groups, including HALT entry and exit.
// Optional macro SEQ_HALT_BUG_EN reproduces the HALT bug (HALT exit with IME=0 skips one PC increment).
module microcode_step_sequencer
    import gb_seq_pkg::*;
#(
    parameter int         STEP_W       = 4,
    parameter logic [7:0] RESET_OPCODE = DEF_RESET_OPCODE
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic              i_Tick,
    input  logic              i_Stall,
    input  logic              i_Instr_Done,
    input  logic              i_Halt_Req,
    input  logic              i_Int_Pending,
    input  logic              i_IME,
    input  logic [7:0]        i_Bus_Data,
    output logic [STEP_W-1:0] o_Cycle_Step,
    output logic [7:0]        o_Opcode,
    output logic              o_CB_Prefix,
    output logic              o_Active,
    output logic              o_PC_Inc,
    output logic              o_Halted,
    output logic              o_Step_Overrun
);
    seq_state_t state;
    logic       adv, fetch, is_cb, suppress;
    logic       in_run, done_next, step_load, step_clear, step_adv;

    assign adv       = i_Tick & !i_Stall;
    assign is_cb     = i_Bus_Data == OPC_CB;
    assign in_run    = state == RUN;
    assign done_next = in_run & i_Instr_Done & !i_Halt_Req;
    // An opcode byte is taken from the bus either from idle fetch or back-to-back at instruction end
    assign fetch     = adv & (state == FETCH0 | done_next);

    assign step_load  = adv & state == FETCH_CB | fetch & !is_cb;
    assign step_clear = adv & in_run & i_Instr_Done & (i_Halt_Req | is_cb);
    assign step_adv   = adv & in_run & !i_Instr_Done;

    assign o_Active = in_run;
    assign o_Halted = state == HALT;
    assign o_PC_Inc = (fetch | adv & state == FETCH_CB) & !suppress;

    cycle_step_shift #(.STEP_W(STEP_W)) u_step (
        .i_Clk    (i_Clk),
        .i_Reset  (i_Reset),
        .i_Load   (step_load),
        .i_Clear  (step_clear),
        .i_Advance(step_adv),
        .o_Step   (o_Cycle_Step),
        .o_Overrun(o_Step_Overrun)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state       <= FETCH0;
            o_Opcode    <= RESET_OPCODE;
            o_CB_Prefix <= 1'b0;
        end else if (fetch) begin
            o_Opcode    <= i_Bus_Data;
            o_CB_Prefix <= is_cb;
            state       <= is_cb ? FETCH_CB : RUN;
        end else if (adv) begin
            case (state)
                FETCH_CB: begin
                    o_Opcode <= i_Bus_Data;
                    state    <= RUN;
                end
                RUN:     state <= i_Instr_Done ? HALT : RUN;
                HALT:    state <= i_Int_Pending ? FETCH0 : HALT;
                default: state <= state;
            endcase
        end
    end

`ifdef SEQ_HALT_BUG_EN
    // Leaving HALT with interrupts disabled makes the next fetch re-read the same byte
    always_ff @(posedge i_Clk) begin
        if (i_Reset)
            suppress <= 1'b0;
        else if (adv & state == HALT & i_Int_Pending & !i_IME)
            suppress <= 1'b1;
        else if (fetch | adv & state == FETCH_CB)
            suppress <= 1'b0;
    end
`else
    logic unused_ime;
    assign suppress   = 1'b0;
    assign unused_ime = i_IME;
`endif
endmodule

// File: tb/tb_microcode_step_sequencer.sv
// tb_microcode_step_sequencer: directed vectors with a queued scoreboard checked by a separate monitor.
module tb_microcode_step_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b0, tick = 1'b0, stall = 1'b0, done = 1'b0, halt = 1'b0, intp = 1'b0, ime = 1'b0;
    logic [7:0] bus = 8'h00;
    logic [3:0] step;
    logic [7:0] opcode;
    logic       cb, active, pc_inc, halted, overrun;

    typedef struct {
        logic       pc;
        logic [3:0] step;
        logic [7:0] op;
        logic       cb, act, hlt, ovr;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0, n_bad = 0;

`ifdef SEQ_HALT_BUG_EN
    localparam logic BUG = 1'b1;
`else
    localparam logic BUG = 1'b0;
`endif

    always #5 clk = ~clk;

    microcode_step_sequencer dut (
        .i_Clk         (clk),
        .i_Reset       (rst),
        .i_Tick        (tick),
        .i_Stall       (stall),
        .i_Instr_Done  (done),
        .i_Halt_Req    (halt),
        .i_Int_Pending (intp),
        .i_IME         (ime),
        .i_Bus_Data    (bus),
        .o_Cycle_Step  (step),
        .o_Opcode      (opcode),
        .o_CB_Prefix   (cb),
        .o_Active      (active),
        .o_PC_Inc      (pc_inc),
        .o_Halted      (halted),
        .o_Step_Overrun(overrun)
    );

    task automatic chk(input string nm, input int idx, input logic [7:0] a, input logic [7:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s vec%0d: got %0h want %0h", nm, idx, a, e);
        end
    endtask

    // Monitor: PC-inc is combinational and read before the edge, registered state after it
    initial begin
        exp_t e;
        logic pc;
        int   idx = 0;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e  = q.pop_front();
                pc = pc_inc;
                @(posedge clk);
                #1;
                idx++;
                chk("pc_inc",  idx, 8'(pc),      8'(e.pc));
                chk("step",    idx, 8'(step),    8'(e.step));
                chk("opcode",  idx, opcode,      e.op);
                chk("cb",      idx, 8'(cb),      8'(e.cb));
                chk("active",  idx, 8'(active),  8'(e.act));
                chk("halted",  idx, 8'(halted),  8'(e.hlt));
                chk("overrun", idx, 8'(overrun), 8'(e.ovr));
            end
        end
    end

    task automatic v(input logic r, t, s, d, h, ip, ie, input logic [7:0] b,
                     input logic epc, input logic [3:0] es, input logic [7:0] eo,
                     input logic ecb, ea, eh, eov);
        exp_t e;
        @(negedge clk);
        rst = r; tick = t; stall = s; done = d; halt = h; intp = ip; ime = ie; bus = b;
        e.pc = epc; e.step = es; e.op = eo; e.cb = ecb; e.act = ea; e.hlt = eh; e.ovr = eov;
        q.push_back(e);
    endtask

    initial begin
        //  r t s d h i e  bus     pc step op     cb a h o
        v(1,0,0,0,0,0,0, 8'h00,  0, 4'h0, 8'h00, 0,0,0,0);
        v(0,1,0,0,0,0,0, 8'h07,  1, 4'h1, 8'h07, 0,1,0,0);
        v(0,1,0,0,0,0,0, 8'hFF,  0, 4'h2, 8'h07, 0,1,0,0);
        v(0,1,0,0,0,0,0, 8'hFF,  0, 4'h4, 8'h07, 0,1,0,0);
        v(0,1,0,1,0,0,0, 8'h3C,  1, 4'h1, 8'h3C, 0,1,0,0);
        v(0,1,0,1,0,0,0, 8'hCB,  1, 4'h0, 8'hCB, 1,0,0,0);
        v(0,1,0,0,0,0,0, 8'h37,  1, 4'h1, 8'h37, 1,1,0,0);
        v(0,1,0,1,0,0,0, 8'h00,  1, 4'h1, 8'h00, 0,1,0,0);
        v(0,0,0,1,0,0,0, 8'h55,  0, 4'h1, 8'h00, 0,1,0,0);
        v(0,1,1,1,0,0,0, 8'h55,  0, 4'h1, 8'h00, 0,1,0,0);
        v(0,1,0,1,1,0,0, 8'h55,  0, 4'h0, 8'h00, 0,0,1,0);
        for (int i = 0; i < 3; i++)
            v(0,1,0,1,0,0,0, 8'h66,  0, 4'h0, 8'h00, 0,0,1,0);
        v(0,1,0,0,0,1,0, 8'h12,  0, 4'h0, 8'h00, 0,0,0,0);
        v(0,1,0,0,0,0,0, 8'h12, !BUG, 4'h1, 8'h12, 0,1,0,0);
        v(0,1,0,1,0,0,0, 8'h34,  1, 4'h1, 8'h34, 0,1,0,0);
        v(0,1,0,0,0,0,0, 8'h00,  0, 4'h2, 8'h34, 0,1,0,0);
        v(0,1,0,0,0,0,0, 8'h00,  0, 4'h4, 8'h34, 0,1,0,0);
        v(0,1,0,0,0,0,0, 8'h00,  0, 4'h8, 8'h34, 0,1,0,0);
        v(0,1,0,0,0,0,0, 8'h00,  0, 4'h8, 8'h34, 0,1,0,1);
        v(0,1,1,1,0,0,0, 8'h00,  0, 4'h8, 8'h34, 0,1,0,1);
        v(0,1,0,1,0,0,0, 8'h00,  1, 4'h1, 8'h00, 0,1,0,1);
        v(0,1,0,1,1,1,1, 8'h00,  0, 4'h0, 8'h00, 0,0,1,1);
        v(0,1,0,0,0,1,1, 8'h00,  0, 4'h0, 8'h00, 0,0,0,1);
        v(0,1,0,0,0,0,0, 8'h07,  1, 4'h1, 8'h07, 0,1,0,1);
        v(1,1,0,0,0,0,0, 8'h99,  0, 4'h0, 8'h00, 0,0,0,0);
        v(0,1,0,0,0,0,0, 8'hCB,  1, 4'h0, 8'hCB, 1,0,0,0);
        v(0,1,0,0,0,0,0, 8'hCB,  1, 4'h1, 8'hCB, 1,1,0,0);
        @(negedge clk);
        tick = 1'b0; done = 1'b0; rst = 1'b0;
        for (int i = 0; i < 10 && q.size() != 0; i++)
            @(negedge clk);
        @(posedge clk);
        #3;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
